// File: rtl/nibble_sub_seq.sv
// Wide subtractor that reuses one 4-bit subtract slice, LSB nibble first, one nibble per clock.
// Optional zero-result flag port enabled by defining NSEQ_ZERO_FLAG_EN.
module nibble_sub_seq #(
  parameter int  NIB = 4,
  localparam int W   = 4 * NIB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         cout
`ifdef NSEQ_ZERO_FLAG_EN
  ,
  output logic         zero
`endif
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         st, st_next;
  logic [W-1:0]   ar, br, wk, wk_merged;
  logic           c;
  logic [IW-1:0]  idx;
  logic [3:0]     an, bn, dn;
  logic           c_out;
  logic           last;
  logic           accept;

  // The one shared slice: a_n + ~b_n + c_in, with c seeded to 1 on capture.
  assign an             = ar[4*idx +: 4];
  assign bn             = br[4*idx +: 4];
  assign {c_out, dn}    = {1'b0, an} + {1'b0, ~bn} + {4'b0000, c};

  assign last   = (idx == IW'(NIB - 1));
  assign accept = start && (st != RUN);

  assign ready = (st != RUN);
  assign busy  = (st == RUN);
  assign done  = (st == DONE);

  // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    wk_merged              = wk;
    wk_merged[4*idx +: 4]  = dn;
  end

  always_comb begin
    st_next = st;
    case (st)
      IDLE:    if (start) st_next = RUN;
      RUN:     if (last)  st_next = DONE;
      DONE:    st_next = start ? RUN : IDLE;
      default: st_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the operand and work registers are plain flops, so they are cleared by reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      idx  <= '0;
      c    <= 1'b0;
      ar   <= '0;
      br   <= '0;
      wk   <= '0;
      d    <= '0;
      cout <= 1'b0;
`ifdef NSEQ_ZERO_FLAG_EN
      zero <= 1'b1;
`endif
    end else begin
      st <= st_next;
      if (accept) begin
        ar  <= a;
        br  <= b;
        c   <= 1'b1;
        idx <= '0;
      end else if (st == RUN) begin
        wk <= wk_merged;
        c  <= c_out;
        if (last) begin
          // Publish the merged word so the final nibble is visible together with the rest.
          d    <= wk_merged;
          cout <= c_out;
`ifdef NSEQ_ZERO_FLAG_EN
          zero <= (wk_merged == '0);
`endif
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Self-checking bench for nibble_sub_seq: directed cases plus random operands against
// a plain-arithmetic reference (d = a - b mod 2^W, cout = a >= b).
module tb_nibble_sub_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, d;
  logic         ready, busy, done, cout;
`ifdef NSEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  nibble_sub_seq #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .cout  (cout)
`ifdef NSEQ_ZERO_FLAG_EN
    ,
    .zero  (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation from IDLE/DONE and wait for its done pulse.
  // hold: keep start high throughout (back-to-back); poke: pulse start mid-RUN with new operands.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit hold, input bit poke);
    int           n;
    int           busy_cnt;
    logic [W-1:0] exp_d;
    logic         exp_c;
    exp_d = av - bv;
    exp_c = (av >= bv);
    check({tag, "_ready_before"}, 64'(ready), 64'd1);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 4 * NIB + 8) begin
      if (busy) busy_cnt++;
      if (poke && n == 1) begin
        check({tag, "_ready_in_run"}, 64'(ready), 64'd0);
        start = 1'b1;
        a     = '1;
        b     = '0;
      end else if (poke && n == 2) begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    // done appears NIB edges after the accepting edge, i.e. NIB+1 cycles counting the accept cycle.
    check({tag, "_latency"}, 64'(n), 64'(NIB));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(NIB));
    check({tag, "_d"}, 64'(d), 64'(exp_d));
    check({tag, "_cout"}, 64'(cout), 64'(exp_c));
`ifdef NSEQ_ZERO_FLAG_EN
    check({tag, "_zero"}, 64'(zero), 64'(exp_d == '0));
`endif
  endtask

  // Drop start and confirm the done pulse lasted one cycle and the block is idle.
  task automatic finish_idle(input string tag);
    start = 1'b0;
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle_ready"}, 64'(ready), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int done_cnt;
    logic [W-1:0] av, bv;
    bit hold;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_d", 64'(d), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
`ifdef NSEQ_ZERO_FLAG_EN
    check("rst_zero", 64'(zero), 64'd1);
`endif
    rst = 1'b0;
    tick();

    run_op("basic", 16'h1234, 16'h0234, 1'b0, 1'b0);
    finish_idle("basic");
    run_op("ripple_pos", 16'h1000, 16'h0001, 1'b0, 1'b0);
    finish_idle("ripple_pos");
    run_op("ripple_neg", 16'h0000, 16'h0001, 1'b0, 1'b0);
    finish_idle("ripple_neg");
    run_op("equal", 16'hABCD, 16'hABCD, 1'b0, 1'b0);
    finish_idle("equal");

    // A start pulse during RUN must be ignored and must not queue a second operation.
    run_op("midstart", 16'h0005, 16'h0003, 1'b0, 1'b1);
    finish_idle("midstart");
    tick();
    check("midstart_no_second_op", 64'(busy), 64'd0);

    // start held high: the edge leaving DONE accepts the next operands.
    run_op("b2b_first", 16'h1111, 16'h0001, 1'b1, 1'b0);
    run_op("b2b_second", 16'h8000, 16'h7FFF, 1'b0, 1'b0);
    finish_idle("b2b");

    // Reset asserted on the 2nd RUN edge discards the partial result.
    a     = 16'h4321;
    b     = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_d", 64'(d), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 3 * NIB; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    run_op("after_rst", 16'h4321, 16'h1234, 1'b0, 1'b0);
    finish_idle("after_rst");

    for (int i = 0; i < 30; i++) begin
      av   = W'($urandom);
      bv   = ($urandom_range(0, 3) == 0) ? av : W'($urandom);
      hold = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), av, bv, hold, 1'b0);
      if (!hold) finish_idle($sformatf("rand%0d", i));
    end
    start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
